sprite_datapath: RTL and testbench
==================================

// Module: sprite_datapath
// PURPOSE
//  Parametrised player datapath for the VGA game: holds the sprite position and the frame timer.
//  Scans an NxN sprite into plot/x/y/colour pixel writes for the VGA adapter.
//  Driven by the game FSM over level-enable/pulse controls.
//  Next generation of the fixed-position, single-pixel datapath.
// PARAMETERS
//  XW        8           x coordinate width
//  YW        8           y coordinate width
//  CW        3           colour width
//  X_INIT    80          x loaded on reset/ld_init
//  Y_INIT    100         y loaded on reset/ld_init
//  X_MAX     159         rightmost screen column
//  Y_MAX     119         bottom screen row
//  SPRITE    4           sprite side in pixels (>=1)
//  TICKS     50_000_000  clk cycles per timer tick (>=2)
//  FG_COLOR  3'b100      sprite colour (red); erase colour is all-zero (black)
// PORTS
//  clk         in   1    system clock, all logic on posedge
//  resetn      in   1    asynchronous active-low reset
//  ld_init     in   1    load X_INIT/Y_INIT; clear goal_hit
//  move_en     in   1    one-step move in direction dir
//  dir         in   2    0=up(y-1) 1=down(y+1) 2=left(x-1) 3=right(x+1)
//  timer_clr   in   1    synchronous clear of the tick counter
//  draw_start  in   1    pulse: start sprite scan
//  erase       in   1    sampled with draw_start: 1=black, 0=FG_COLOR
//  tick        out  1    one-cycle pulse every TICKS cycles
//  plot        out  1    pixel write strobe to VGA adapter
//  x_out       out  XW   pixel x
//  y_out       out  YW   pixel y
//  color_out   out  CW   pixel colour
//  draw_busy   out  1    high from the cycle after draw_start until draw_done
//  draw_done   out  1    one-cycle pulse after the last pixel
//  goal_hit    out  1    sprite origin reached goal (see CONFIGURATION)
// BEHAVIOUR
//  Reset: pos=(X_INIT,Y_INIT); timer=0; FSM=IDLE. All outputs are 0.
//  Reset mid-scan aborts the scan immediately (plot=0, no draw_done).
//  Timer: width $clog2(TICKS). Increments every cycle.
//   - At TICKS-1 it wraps to 0 and tick is registered high for the next cycle.
//   - timer_clr zeroes the counter and suppresses tick that cycle. Tick period = TICKS cycles.
//  Position:
//   - Priority: ld_init > move_en.
//   - Legal range x in [0, X_MAX-SPRITE+1], y in [0, Y_MAX-SPRITE+1].
//   - A move that would leave the range saturates (pos unchanged); no wrap-around.
//   - move_en is ignored while draw_busy=1, so the sprite is not torn. ld_init is always honoured.
//  Draw FSM, states IDLE -> SCAN -> DONE -> IDLE:
//   - IDLE: on draw_start, latch base=(pos), colour=erase?0:FG_COLOR, (ox,oy)=(0,0); go to SCAN.
//   - SCAN: plot=1 every cycle; x_out=base_x+ox, y_out=base_y+oy (registered outputs).
//     ox increments, wraps at SPRITE-1 and bumps oy (row-major).
//     After pixel (SPRITE-1,SPRITE-1), go to DONE.
//   - DONE: plot=0, draw_done=1 for one cycle; go to IDLE.
//   - First plot is 1 cycle after draw_start. Exactly SPRITE*SPRITE plot cycles, contiguous.
//   - draw_start outside IDLE is ignored. x_out/y_out/color_out hold their last values in IDLE.
// CONFIGURATION
//  GOAL_DETECT_EN defined:
//   - Extra parameters GOAL_X=150, GOAL_Y=0.
//   - goal_hit is registered; it is set the cycle after pos==(GOAL_X,GOAL_Y).
//   - It is sticky until ld_init or reset.
//  GOAL_DETECT_EN undefined: goal_hit is constant 0 and no comparator is built.
// TESTING
//  1. Reset, then TICKS=10: tick pulses at cycles 10, 20, 30.
//     Pulse timer_clr at cycle 15: the next tick is at cycle 25.
//  2. draw_start, erase=0, pos=(80,100), SPRITE=4: 16 plot cycles.
//     Pixels (80..83,100..103) row-major, colour 3'b100, then draw_done for one cycle.
//  3. pos=(0,0): move left and up 3 times each -> pos stays (0,0).
//     Move right to x=156 -> further right moves are ignored.
//  4. move_en during a scan: pos is unchanged and all pixels use the latched base.
//     draw_start while busy: no restart, still 16 plots.
//  5. Assert resetn low at the 7th plot: plot=0 immediately, no draw_done.
//     After release: pos=(80,100), FSM idle.
//  6. GOAL_DETECT_EN, goal (150,0): drive to (150,0) -> goal_hit=1 next cycle.
//     Move away -> still 1. ld_init -> 0.

Source files
------------

// File: rtl/sprite_datapath.sv
// Player sprite datapath: position, frame timer and NxN sprite scan.
// Optional goal detector enabled by defining GOAL_DETECT_EN.
module sprite_datapath #(
  parameter int XW = 8,
  parameter int YW = 8,
  parameter int CW = 3,
  parameter int X_INIT = 80,
  parameter int Y_INIT = 100,
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119,
  parameter int SPRITE = 4,
  parameter int TICKS = 50_000_000,
  parameter logic [CW-1:0] FG_COLOR = 3'b100
`ifdef GOAL_DETECT_EN
  ,
  parameter int GOAL_X = 150,
  parameter int GOAL_Y = 0
`endif
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          ld_init,
  input  logic          move_en,
  input  logic [1:0]    dir,
  input  logic          timer_clr,
  input  logic          draw_start,
  input  logic          erase,
  output logic          tick,
  output logic          plot,
  output logic [XW-1:0] x_out,
  output logic [YW-1:0] y_out,
  output logic [CW-1:0] color_out,
  output logic          draw_busy,
  output logic          draw_done,
  output logic          goal_hit
);

  localparam int TW = $clog2(TICKS);
  localparam int OW = (SPRITE > 1) ? $clog2(SPRITE) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TICKS - 1);
  localparam logic [XW-1:0] X_LIM = XW'(X_MAX - SPRITE + 1);
  localparam logic [YW-1:0] Y_LIM = YW'(Y_MAX - SPRITE + 1);
  localparam logic [XW-1:0] X_RST = XW'(X_INIT);
  localparam logic [YW-1:0] Y_RST = YW'(Y_INIT);
  localparam logic [OW-1:0] O_LAST = OW'(SPRITE - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  logic [TW-1:0] tmr;
  logic [XW-1:0] pos_x;
  logic [YW-1:0] pos_y;

  state_t        state_q, state_d;
  logic [XW-1:0] bx_q, bx_d;
  logic [YW-1:0] by_q, by_d;
  logic [OW-1:0] ox_q, ox_d;
  logic [OW-1:0] oy_q, oy_d;
  logic [XW-1:0] x_d;
  logic [YW-1:0] y_d;
  logic [CW-1:0] c_d;
  logic          plot_d, done_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tmr  <= '0;
      tick <= 1'b0;
    end else if (timer_clr) begin
      tmr  <= '0;
      tick <= 1'b0;
    end else if (tmr == T_LAST) begin
      tmr  <= '0;
      tick <= 1'b1;
    end else begin
      tmr  <= tmr + 1'b1;
      tick <= 1'b0;
    end
  end

  logic up, dn, lt, rt;
  assign up = (dir == 2'd0);
  assign dn = (dir == 2'd1);
  assign lt = (dir == 2'd2);
  assign rt = (dir == 2'd3);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pos_x <= X_RST;
      pos_y <= Y_RST;
    end else if (ld_init) begin
      pos_x <= X_RST;
      pos_y <= Y_RST;
    end else if (move_en && !draw_busy) begin
      // Out-of-range moves leave the position unchanged
      unique case (1'b1)
        up: if (pos_y != '0) pos_y <= pos_y - 1'b1;
        dn: if (pos_y < Y_LIM) pos_y <= pos_y + 1'b1;
        lt: if (pos_x != '0) pos_x <= pos_x - 1'b1;
        rt: if (pos_x < X_LIM) pos_x <= pos_x + 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      bx_q      <= '0;
      by_q      <= '0;
      ox_q      <= '0;
      oy_q      <= '0;
      x_out     <= '0;
      y_out     <= '0;
      color_out <= '0;
      plot      <= 1'b0;
      draw_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      bx_q      <= bx_d;
      by_q      <= by_d;
      ox_q      <= ox_d;
      oy_q      <= oy_d;
      x_out     <= x_d;
      y_out     <= y_d;
      color_out <= c_d;
      plot      <= plot_d;
      draw_done <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bx_d    = bx_q;
    by_d    = by_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    x_d     = x_out;
    y_d     = y_out;
    c_d     = color_out;
    plot_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (draw_start) begin
          state_d = SCAN;
          bx_d    = pos_x;
          by_d    = pos_y;
          ox_d    = '0;
          oy_d    = '0;
          x_d     = pos_x;
          y_d     = pos_y;
          c_d     = erase ? '0 : FG_COLOR;
          plot_d  = 1'b1;
        end
      end
      SCAN: begin
        if (ox_q == O_LAST && oy_q == O_LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          if (ox_q == O_LAST) begin
            ox_d = '0;
            oy_d = oy_q + 1'b1;
          end else begin
            ox_d = ox_q + 1'b1;
          end
          x_d    = bx_q + XW'(ox_d);
          y_d    = by_q + YW'(oy_d);
          plot_d = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign draw_busy = (state_q != IDLE);

`ifdef GOAL_DETECT_EN
  localparam logic [XW-1:0] GX = XW'(GOAL_X);
  localparam logic [YW-1:0] GY = YW'(GOAL_Y);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      goal_hit <= 1'b0;
    end else if (ld_init) begin
      goal_hit <= 1'b0;
    end else if (pos_x == GX && pos_y == GY) begin
      goal_hit <= 1'b1;
    end
  end
`else
  assign goal_hit = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_datapath.sv
// Bench for sprite_datapath: cycle model plus directed scenarios.
// Goal checks follow GOAL_DETECT_EN when it is defined.
module tb_sprite_datapath;

  localparam int TICKS = 10;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       ld_init = 1'b0;
  logic       move_en = 1'b0;
  logic [1:0] dir = 2'd0;
  logic       timer_clr = 1'b0;
  logic       draw_start = 1'b0;
  logic       erase = 1'b0;
  logic       tick, plot, draw_busy, draw_done, goal_hit;
  logic [7:0] x_out, y_out;
  logic [2:0] color_out;

  sprite_datapath #(.TICKS(TICKS)) dut (
    .clk(clk), .resetn(resetn), .ld_init(ld_init),
    .move_en(move_en), .dir(dir), .timer_clr(timer_clr),
    .draw_start(draw_start), .erase(erase), .tick(tick),
    .plot(plot), .x_out(x_out), .y_out(y_out),
    .color_out(color_out), .draw_busy(draw_busy),
    .draw_done(draw_done), .goal_hit(goal_hit)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    bit plot;
    bit done;
    int x;
    int y;
    int c;
  } ev_t;

  typedef struct {
    int x;
    int y;
    int c;
  } px_t;

  ev_t q[$];
  int  m_n, m_since, mx, my, m_xo, m_yo, m_co;
  bit  m_tick, m_plot, m_done, m_busy, m_goal;

  // Reference model: expected outputs after each clock edge
  always @(posedge clk or negedge resetn) begin
    int px, py;
    bit pbusy;
    ev_t e;
    if (!resetn) begin
      q.delete();
      m_n = 0; m_since = 0; mx = 80; my = 100;
      m_xo = 0; m_yo = 0; m_co = 0;
      m_tick = 0; m_plot = 0; m_done = 0; m_busy = 0; m_goal = 0;
    end else begin
      m_n++;
      if (timer_clr) begin
        m_since = 0;
        m_tick = 0;
      end else begin
        m_since++;
        m_tick = (m_since == TICKS);
        if (m_tick) m_since = 0;
      end
      px = mx;
      py = my;
      pbusy = m_busy;
      if (draw_start && !pbusy) begin
        for (int oy = 0; oy < 4; oy++)
          for (int ox = 0; ox < 4; ox++)
            q.push_back('{1, 0, px + ox, py + oy, erase ? 0 : 4});
        q.push_back('{0, 1, 0, 0, 0});
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        m_plot = e.plot;
        m_done = e.done;
        if (e.plot) begin
          m_xo = e.x; m_yo = e.y; m_co = e.c;
        end
        m_busy = 1;
      end else begin
        m_plot = 0; m_done = 0; m_busy = 0;
      end
`ifdef GOAL_DETECT_EN
      m_goal = ld_init ? 0 : (m_goal || (px == 150 && py == 0));
`else
      m_goal = 0;
`endif
      if (ld_init) begin
        mx = 80; my = 100;
      end else if (move_en && !pbusy) begin
        case (dir)
          2'd0: if (my > 0) my--;
          2'd1: if (my < 116) my++;
          2'd2: if (mx > 0) mx--;
          2'd3: if (mx < 156) mx++;
        endcase
      end
    end
  end

  int  tick_at[$];
  px_t pix[$];
  int  dones;

  always @(negedge clk) begin
    check("tick", tick, m_tick);
    check("plot", plot, m_plot);
    check("draw_done", draw_done, m_done);
    check("draw_busy", draw_busy, m_busy);
    check("x_out", x_out, m_xo);
    check("y_out", y_out, m_yo);
    check("color_out", color_out, m_co);
    check("goal_hit", goal_hit, m_goal);
    if (tick) tick_at.push_back(m_n);
    if (plot) pix.push_back('{int'(x_out), int'(y_out), int'(color_out)});
    if (draw_done) dones++;
  end

  task automatic step(input int k = 1);
    repeat (k) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step(2);
    resetn = 1'b1;
  endtask

  task automatic draw(input bit er);
    pix.delete();
    dones = 0;
    draw_start = 1'b1;
    erase = er;
    step();
    draw_start = 1'b0;
    erase = 1'b0;
    step(20);
  endtask

  task automatic mv(input logic [1:0] d, input int k);
    move_en = 1'b1;
    dir = d;
    step(k);
    move_en = 1'b0;
  endtask

  initial begin
    step(3);
    check("rst_plot", plot, 0);
    check("rst_x", x_out, 0);
    check("rst_busy", draw_busy, 0);
    resetn = 1'b1;

    tick_at.delete();
    step(32);
    check("tick_cnt", tick_at.size(), 3);
    if (tick_at.size() == 3) begin
      check("tick0", tick_at[0], 10);
      check("tick1", tick_at[1], 20);
      check("tick2", tick_at[2], 30);
    end

    do_reset();
    tick_at.delete();
    for (int i = 1; i <= 27; i++) begin
      timer_clr = (i == 15);
      step();
    end
    timer_clr = 1'b0;
    check("clr_cnt", tick_at.size(), 2);
    if (tick_at.size() == 2) begin
      check("clr_t0", tick_at[0], 10);
      check("clr_t1", tick_at[1], 25);
    end

    draw(1'b0);
    check("d_cnt", pix.size(), 16);
    check("d_done", dones, 1);
    if (pix.size() == 16) begin
      check("d0_x", pix[0].x, 80);
      check("d0_y", pix[0].y, 100);
      check("d0_c", pix[0].c, 4);
      check("d4_x", pix[4].x, 80);
      check("d4_y", pix[4].y, 101);
      check("d15_x", pix[15].x, 83);
      check("d15_y", pix[15].y, 103);
    end

    draw(1'b1);
    check("er_cnt", pix.size(), 16);
    if (pix.size() > 0) check("er_c", pix[0].c, 0);

    mv(2'd2, 83);
    mv(2'd0, 103);
    draw(1'b0);
    if (pix.size() > 0) begin
      check("sat_x0", pix[0].x, 0);
      check("sat_y0", pix[0].y, 0);
    end
    mv(2'd3, 170);
    draw(1'b0);
    if (pix.size() == 16) begin
      check("sat_x156", pix[0].x, 156);
      check("sat_x159", pix[15].x, 159);
    end

    ld_init = 1'b1;
    step();
    ld_init = 1'b0;
    pix.delete();
    dones = 0;
    draw_start = 1'b1;
    step();
    move_en = 1'b1;
    dir = 2'd3;
    step(5);
    move_en = 1'b0;
    draw_start = 1'b0;
    step(20);
    check("busy_cnt", pix.size(), 16);
    check("busy_done", dones, 1);
    if (pix.size() == 16) begin
      check("busy_x15", pix[15].x, 83);
      check("busy_y15", pix[15].y, 103);
    end
    draw(1'b0);
    if (pix.size() > 0) check("busy_pos", pix[0].x, 80);

    mv(2'd1, 2);
    pix.delete();
    dones = 0;
    draw_start = 1'b1;
    step();
    draw_start = 1'b0;
    step(6);
    check("ab_plot7", plot, 1);
    check("ab_seen", pix.size(), 6);
    resetn = 1'b0;
    #1;
    check("ab_plot", plot, 0);
    check("ab_busy", draw_busy, 0);
    step(3);
    resetn = 1'b1;
    step(20);
    check("ab_done", dones, 0);
    check("ab_cnt", pix.size(), 6);
    draw(1'b0);
    if (pix.size() > 0) begin
      check("ab_x", pix[0].x, 80);
      check("ab_y", pix[0].y, 100);
    end

`ifdef GOAL_DETECT_EN
    ld_init = 1'b1;
    step();
    ld_init = 1'b0;
    mv(2'd3, 70);
    mv(2'd0, 100);
    check("goal_pre", goal_hit, 0);
    step();
    check("goal_set", goal_hit, 1);
    mv(2'd1, 2);
    step();
    check("goal_stk", goal_hit, 1);
    ld_init = 1'b1;
    step();
    ld_init = 1'b0;
    check("goal_clr", goal_hit, 0);
`else
    check("goal_off", goal_hit, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
